if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that consumes the program counter and returns instructions to the decode stage of the RISC-V pipeline.
- Accepts the current PC and issues a read to instruction memory, absorbing the memory's wait states.
- Registers the returned instruction together with its PC and hands it to decode through a valid/ready handshake.
- Handles stalls from decode, squashes on taken branches, and flags misaligned PCs.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- NOP_INSTR, 32'h00000013, value driven on IF_INSTR when no valid instruction is held (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC_IN  in  ADDR_W  current PC from the PC register.
- PC_VALID  in  1  PC_IN is valid for fetch.
- PC_ACCEPT  out  1  one-cycle pulse: PC_IN captured; the PC register may advance.
- FLUSH  in  1  branch taken in EX; squash everything in flight.
- IMEM_ADDR  out  ADDR_W  instruction-memory address.
- IMEM_READ  out  1  read request.
- IMEM_BUSY  in  1  memory not ready; IMEM_RDATA is valid in any FETCH cycle with IMEM_BUSY=0.
- IMEM_RDATA  in  DATA_W  read data.
- IF_INSTR  out  DATA_W  instruction to decode.
- IF_PC  out  ADDR_W  PC of IF_INSTR.
- IF_VALID  out  1  IF_INSTR/IF_PC valid.
- IF_MISALIGN  out  1  qualifies IF_VALID; the PC had PC[1:0]!=0.
- ID_READY  in  1  decode accepts the output this cycle.

Behaviour:
- Reset values:
  - IMEM_READ=0, IMEM_ADDR=0, PC_ACCEPT=0.
  - IF_VALID=0, IF_MISALIGN=0, IF_INSTR=NOP_INSTR, IF_PC=0.
  - Skid buffer empty; state IDLE.
  - Reset takes effect immediately, including mid-transaction; an abandoned memory read is dropped.
- Output transfer: occurs on an edge where IF_VALID=1 and ID_READY=1. Output is "free" when IF_VALID=0 or a transfer occurs that edge.
- State IDLE:
  - If PC_VALID=1, FLUSH=0 and PC_IN[1:0]==0: capture PC_IN into IMEM_ADDR, set IMEM_READ=1, pulse PC_ACCEPT, go to FETCH.
  - If PC_VALID=1, FLUSH=0, PC_IN[1:0]!=0 and the output is free: no memory access. Load IF_PC=PC_IN, IF_INSTR=NOP_INSTR, IF_VALID=1, IF_MISALIGN=1; pulse PC_ACCEPT; stay in IDLE.
  - If misaligned and the output is not free: wait; no PC_ACCEPT.
- State FETCH:
  - IMEM_READ stays 1 and IMEM_ADDR stays stable while IMEM_BUSY=1.
  - On the first cycle with IMEM_BUSY=0, IMEM_READ drops at the edge.
  - If the output is free: load IF_INSTR=IMEM_RDATA, IF_PC=IMEM_ADDR, IF_VALID=1, IF_MISALIGN=0; go to IDLE.
  - Otherwise: store data and PC in the skid buffer; go to HOLD.
- State HOLD:
  - When the output is free, move the skid buffer to the output (IF_VALID=1) and go to IDLE.
  - PC_VALID is ignored in HOLD.
- Latency and throughput:
  - With zero wait states: PC_VALID sampled at edge N, IF_VALID=1 after edge N+1.
  - Each IMEM_BUSY cycle adds one cycle.
  - Peak throughput is one instruction per 2 cycles.
- IF_VALID clears on a transfer edge unless new data loads on the same edge.
- FLUSH (synchronous, sampled each edge):
  - IF_VALID=0, IF_MISALIGN=0, IF_INSTR=NOP_INSTR, skid buffer cleared.
  - In FETCH: enter a DRAIN state. IMEM_READ and IMEM_ADDR are held until IMEM_BUSY=0, the returned data is discarded, then go to IDLE.
  - In HOLD: go to IDLE.
  - In IDLE: no fetch issued that cycle and no PC_ACCEPT.
  - FLUSH has priority over ID_READY and PC_VALID on the same edge.
  - FLUSH during DRAIN has no additional effect.
- PC_ACCEPT is never asserted for two consecutive cycles.
- PC_ACCEPT is never asserted outside IDLE.

Test Plan:
- Zero-wait fetch: PC_IN=0x100, PC_VALID=1, IMEM_BUSY=0, IMEM_RDATA=0x00500093, ID_READY=1 -> PC_ACCEPT pulses 1 cycle, IMEM_ADDR=0x100; IF_VALID=1, IF_INSTR=0x00500093, IF_PC=0x100 two edges after PC_VALID.
- Wait states: IMEM_BUSY=1 for 3 cycles on PC 0x104 -> IMEM_READ and IMEM_ADDR stable for 3 cycles; IF_VALID rises one edge after IMEM_BUSY falls; total latency 5 edges.
- Decode stall: ID_READY=0 with first instruction held, second fetch returns 0x00A00113 -> HOLD entered, IF_INSTR stays at first value; raise ID_READY -> next edge IF_INSTR=0x00A00113, IF_PC=0x104; no data lost or duplicated.
- Flush in flight: FLUSH=1 during FETCH with IMEM_BUSY=1 -> IF_VALID=0 next edge, IMEM_READ held until IMEM_BUSY=0, returned data never appears on IF_INSTR, then PC 0x200 fetches normally.
- Misaligned PC: PC_IN=0x102 -> IMEM_READ stays 0, IF_VALID=1, IF_MISALIGN=1, IF_INSTR=0x00000013, IF_PC=0x102.
- Async reset mid-FETCH: RESET asserted between edges -> IMEM_READ=0, IF_VALID=0, IF_INSTR=0x00000013 immediately; after release, fetch from PC_IN=0x0 proceeds normally.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the RISC-V pipeline. Takes the current PC from
// the PC register, reads instruction memory (absorbing its wait states) and
// presents the returned instruction plus its PC to decode over a valid/ready
// handshake. A one-entry skid buffer holds a returned instruction while
// decode is stalled. Taken branches (FLUSH) squash everything in flight,
// and misaligned PCs are passed to decode as a flagged NOP with no memory
// access.
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   PC_IN, PC_VALID       PC offered for fetch
//   PC_ACCEPT             one-cycle pulse: PC_IN captured, PC may advance
//   FLUSH                 taken branch in EX; squash in-flight work
//   IMEM_ADDR, IMEM_READ  instruction-memory request
//   IMEM_BUSY, IMEM_RDATA memory wait state / read data
//   IF_INSTR, IF_PC       instruction and its PC towards decode
//   IF_VALID, IF_MISALIGN output valid, misaligned-PC qualifier
//   ID_READY              decode accepts the output this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC_IN,
  input  logic              PC_VALID,
  output logic              PC_ACCEPT,
  input  logic              FLUSH,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic              IMEM_READ,
  input  logic              IMEM_BUSY,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic [DATA_W-1:0] IF_INSTR,
  output logic [ADDR_W-1:0] IF_PC,
  output logic              IF_VALID,
  output logic              IF_MISALIGN,
  input  logic              ID_READY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Registered state
  state_t              state_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic                imem_read_r;
  logic                pc_accept_r;
  logic                if_valid_r;
  logic                if_misalign_r;
  logic [DATA_W-1:0]   if_instr_r;
  logic [ADDR_W-1:0]   if_pc_r;
  logic                skid_valid_r;
  logic [DATA_W-1:0]   skid_instr_r;
  logic [ADDR_W-1:0]   skid_pc_r;

  // Next-state values
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   imem_addr_nxt_s;
  logic                imem_read_nxt_s;
  logic                pc_accept_nxt_s;
  logic                if_valid_nxt_s;
  logic                if_misalign_nxt_s;
  logic [DATA_W-1:0]   if_instr_nxt_s;
  logic [ADDR_W-1:0]   if_pc_nxt_s;
  logic                skid_valid_nxt_s;
  logic [DATA_W-1:0]   skid_instr_nxt_s;
  logic [ADDR_W-1:0]   skid_pc_nxt_s;

  // Handshake helpers
  logic                xfer_s;
  logic                out_free_s;
  logic                pc_aligned_s;

  // Decode handshake: a transfer frees the output register on this edge
  always_comb begin
    xfer_s       = if_valid_r & ID_READY;
    out_free_s   = (~if_valid_r) | ID_READY;
    pc_aligned_s = (PC_IN[1:0] == 2'b00);
  end

  // Next-state and output computation
  always_comb begin
    state_nxt_s       = state_r;
    imem_addr_nxt_s   = imem_addr_r;
    imem_read_nxt_s   = imem_read_r;
    pc_accept_nxt_s   = 1'b0;
    if_valid_nxt_s    = if_valid_r;
    if_misalign_nxt_s = if_misalign_r;
    if_instr_nxt_s    = if_instr_r;
    if_pc_nxt_s       = if_pc_r;
    skid_valid_nxt_s  = skid_valid_r;
    skid_instr_nxt_s  = skid_instr_r;
    skid_pc_nxt_s     = skid_pc_r;

    // A consumed output empties the register unless a load below refills it
    if (xfer_s) begin
      if_valid_nxt_s    = 1'b0;
      if_misalign_nxt_s = 1'b0;
      if_instr_nxt_s    = NOP_INSTR;
    end else begin
      if_valid_nxt_s    = if_valid_r;
    end

    if (FLUSH) begin
      if_valid_nxt_s    = 1'b0;
      if_misalign_nxt_s = 1'b0;
      if_instr_nxt_s    = NOP_INSTR;
      skid_valid_nxt_s  = 1'b0;
      case (state_r)
        ST_FETCH: begin
          // A read completing on the flush edge is simply dropped;
          // otherwise keep the request up until memory finishes.
          if (IMEM_BUSY) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s     = ST_IDLE;
            imem_read_nxt_s = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (IMEM_BUSY) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s     = ST_IDLE;
            imem_read_nxt_s = 1'b0;
          end
        end
        ST_HOLD: begin
          state_nxt_s = ST_IDLE;
        end
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          imem_read_nxt_s = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          // PC_IN still shows the old PC in the cycle PC_ACCEPT is high,
          // so never accept back-to-back.
          if (PC_VALID && !pc_accept_r) begin
            if (pc_aligned_s) begin
              imem_addr_nxt_s = PC_IN;
              imem_read_nxt_s = 1'b1;
              pc_accept_nxt_s = 1'b1;
              state_nxt_s     = ST_FETCH;
            end else if (out_free_s) begin
              if_valid_nxt_s    = 1'b1;
              if_misalign_nxt_s = 1'b1;
              if_instr_nxt_s    = NOP_INSTR;
              if_pc_nxt_s       = PC_IN;
              pc_accept_nxt_s   = 1'b1;
              state_nxt_s       = ST_IDLE;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (!IMEM_BUSY) begin
            imem_read_nxt_s = 1'b0;
            if (out_free_s) begin
              if_valid_nxt_s    = 1'b1;
              if_misalign_nxt_s = 1'b0;
              if_instr_nxt_s    = IMEM_RDATA;
              if_pc_nxt_s       = imem_addr_r;
              state_nxt_s       = ST_IDLE;
            end else begin
              skid_valid_nxt_s = 1'b1;
              skid_instr_nxt_s = IMEM_RDATA;
              skid_pc_nxt_s    = imem_addr_r;
              state_nxt_s      = ST_HOLD;
            end
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (out_free_s) begin
            if_valid_nxt_s    = 1'b1;
            if_misalign_nxt_s = 1'b0;
            if_instr_nxt_s    = skid_instr_r;
            if_pc_nxt_s       = skid_pc_r;
            skid_valid_nxt_s  = 1'b0;
            state_nxt_s       = ST_IDLE;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (!IMEM_BUSY) begin
            imem_read_nxt_s = 1'b0;
            state_nxt_s     = ST_IDLE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          imem_read_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      imem_addr_r   <= {ADDR_W{1'b0}};
      imem_read_r   <= 1'b0;
      pc_accept_r   <= 1'b0;
      if_valid_r    <= 1'b0;
      if_misalign_r <= 1'b0;
      if_instr_r    <= NOP_INSTR;
      if_pc_r       <= {ADDR_W{1'b0}};
      skid_valid_r  <= 1'b0;
      skid_instr_r  <= NOP_INSTR;
      skid_pc_r     <= {ADDR_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      imem_addr_r   <= imem_addr_nxt_s;
      imem_read_r   <= imem_read_nxt_s;
      pc_accept_r   <= pc_accept_nxt_s;
      if_valid_r    <= if_valid_nxt_s;
      if_misalign_r <= if_misalign_nxt_s;
      if_instr_r    <= if_instr_nxt_s;
      if_pc_r       <= if_pc_nxt_s;
      skid_valid_r  <= skid_valid_nxt_s;
      skid_instr_r  <= skid_instr_nxt_s;
      skid_pc_r     <= skid_pc_nxt_s;
    end
  end

  assign PC_ACCEPT   = pc_accept_r;
  assign IMEM_ADDR   = imem_addr_r;
  assign IMEM_READ   = imem_read_r;
  assign IF_VALID    = if_valid_r;
  assign IF_MISALIGN = if_misalign_r;
  assign IF_INSTR    = if_instr_r;
  assign IF_PC       = if_pc_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. A transaction-level model (one
// outstanding memory read plus a queue of instructions waiting for decode)
// predicts every output each cycle; directed scenarios add hand-computed
// literal expectations, then a randomized phase drives a PC register model.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC_IN;
  logic        PC_VALID;
  logic        PC_ACCEPT;
  logic        FLUSH;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic        IMEM_BUSY;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        IF_VALID;
  logic        IF_MISALIGN;
  logic        ID_READY;

  always #5 CLK = ~CLK;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(32'h00000013)) dut (
    .CLK(CLK), .RESET(RESET), .PC_IN(PC_IN), .PC_VALID(PC_VALID),
    .PC_ACCEPT(PC_ACCEPT), .FLUSH(FLUSH), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READ(IMEM_READ), .IMEM_BUSY(IMEM_BUSY), .IMEM_RDATA(IMEM_RDATA),
    .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .IF_VALID(IF_VALID),
    .IF_MISALIGN(IF_MISALIGN), .ID_READY(ID_READY)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        q[$];      // head = what decode sees, second = stalled return
  bit          m_pend;    // a memory read is outstanding
  bit          m_drop;    // outstanding read was squashed
  bit          m_acc;     // PC_ACCEPT expected this cycle
  logic [31:0] m_addr;    // last issued fetch address
  logic [31:0] m_pc;      // last PC presented to decode

  initial begin
    forever begin : step
      bit xfer;
      bit free_o;
      bit acc_n;
      int sz_pre;
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        q.delete();
        m_pend = 1'b0; m_drop = 1'b0; m_acc = 1'b0;
        m_addr = 32'h0; m_pc = 32'h0;
      end else begin
        sz_pre = q.size();
        xfer   = (sz_pre > 0) && ID_READY;
        free_o = (sz_pre == 0) || xfer;
        acc_n  = 1'b0;
        if (FLUSH) begin
          q.delete();
          if (m_pend) begin
            if (!IMEM_BUSY) begin m_pend = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
          end
        end else begin
          if (xfer) void'(q.pop_front());
          if (m_pend) begin
            if (!IMEM_BUSY) begin
              if (!m_drop) q.push_back(ent_t'{instr: IMEM_RDATA, pc: m_addr, mis: 1'b0});
              m_pend = 1'b0;
              m_drop = 1'b0;
            end
          end else if (sz_pre <= 1 && PC_VALID && !m_acc) begin
            if (PC_IN[1:0] == 2'b00) begin
              m_pend = 1'b1; m_addr = PC_IN; acc_n = 1'b1;
            end else if (free_o) begin
              q.push_back(ent_t'{instr: NOP, pc: PC_IN, mis: 1'b1});
              acc_n = 1'b1;
            end
          end
        end
        m_acc = acc_n;
        if (q.size() > 0) m_pc = q[0].pc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en && !RESET) begin
      check("pc_accept",   32'(PC_ACCEPT),   32'(m_acc));
      check("imem_read",   32'(IMEM_READ),   32'(m_pend));
      check("imem_addr",   IMEM_ADDR,        m_addr);
      check("if_valid",    32'(IF_VALID),    32'(q.size() > 0));
      check("if_misalign", 32'(IF_MISALIGN), (q.size() > 0) ? 32'(q[0].mis) : 32'h0);
      check("if_instr",    IF_INSTR,         (q.size() > 0) ? q[0].instr : NOP);
      check("if_pc",       IF_PC,            m_pc);
    end
  end

  // Drive one cycle of inputs, then wait for the next falling edge
  task automatic tick(input bit pv, input logic [31:0] pc, input bit busy,
                      input logic [31:0] rd, input bit rdy, input bit fl);
    PC_VALID = pv; PC_IN = pc; IMEM_BUSY = busy;
    IMEM_RDATA = rd; ID_READY = rdy; FLUSH = fl;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc_cur;
    RESET = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_imem_read", 32'(IMEM_READ), 32'h0);
    check("rst_imem_addr", IMEM_ADDR, 32'h0);
    check("rst_pc_accept", 32'(PC_ACCEPT), 32'h0);
    check("rst_if_valid", 32'(IF_VALID), 32'h0);
    check("rst_if_misalign", 32'(IF_MISALIGN), 32'h0);
    check("rst_if_instr", IF_INSTR, NOP);
    check("rst_if_pc", IF_PC, 32'h0);
    RESET = 1'b0;
    chk_en = 1'b1;

    // Zero-wait fetch
    tick(1'b1, 32'h100, 1'b0, 32'h00500093, 1'b1, 1'b0);
    check("zw_accept", 32'(PC_ACCEPT), 32'h1);
    check("zw_addr", IMEM_ADDR, 32'h100);
    check("zw_read", 32'(IMEM_READ), 32'h1);
    tick(1'b0, 32'h100, 1'b0, 32'h00500093, 1'b1, 1'b0);
    check("zw_valid", 32'(IF_VALID), 32'h1);
    check("zw_instr", IF_INSTR, 32'h00500093);
    check("zw_pc", IF_PC, 32'h100);
    check("zw_accept_off", 32'(PC_ACCEPT), 32'h0);
    check("model_zw_instr", q[0].instr, 32'h00500093);

    // Wait states: three busy cycles at 0x104
    tick(1'b1, 32'h104, 1'b1, 32'h00A00113, 1'b1, 1'b0);
    check("ws_accept", 32'(PC_ACCEPT), 32'h1);
    check("ws_valid_drop", 32'(IF_VALID), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h104, 1'b1, 32'h00A00113, 1'b1, 1'b0);
      check("ws_read_held", 32'(IMEM_READ), 32'h1);
      check("ws_addr_held", IMEM_ADDR, 32'h104);
      check("ws_not_valid", 32'(IF_VALID), 32'h0);
    end
    tick(1'b0, 32'h104, 1'b0, 32'h00A00113, 1'b1, 1'b0);
    check("ws_valid", 32'(IF_VALID), 32'h1);
    check("ws_instr", IF_INSTR, 32'h00A00113);
    check("ws_read_drop", 32'(IMEM_READ), 32'h0);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Decode stall with a second fetch landing in the skid buffer
    tick(1'b1, 32'h100, 1'b0, 32'h00500093, 1'b0, 1'b0);
    tick(1'b0, 32'h100, 1'b0, 32'h00500093, 1'b0, 1'b0);
    tick(1'b1, 32'h104, 1'b0, 32'h00A00113, 1'b0, 1'b0);
    tick(1'b0, 32'h104, 1'b0, 32'h00A00113, 1'b0, 1'b0);
    check("st_instr_held", IF_INSTR, 32'h00500093);
    tick(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
    check("st_instr_still", IF_INSTR, 32'h00500093);
    check("st_no_accept", 32'(PC_ACCEPT), 32'h0);
    check("st_no_read", 32'(IMEM_READ), 32'h0);
    check("model_st_depth", 32'(q.size()), 32'h2);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("st_second_instr", IF_INSTR, 32'h00A00113);
    check("st_second_pc", IF_PC, 32'h104);
    check("st_second_valid", 32'(IF_VALID), 32'h1);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("st_drained", 32'(IF_VALID), 32'h0);

    // Flush while a read is in flight
    tick(1'b1, 32'h17C, 1'b0, 32'h11111111, 1'b0, 1'b0);
    tick(1'b0, 32'h17C, 1'b0, 32'h11111111, 1'b0, 1'b0);
    tick(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h180, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    check("fl_valid", 32'(IF_VALID), 32'h0);
    check("fl_instr", IF_INSTR, NOP);
    check("fl_read_held", 32'(IMEM_READ), 32'h1);
    tick(1'b0, 32'h180, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    check("fl_read_held2", 32'(IMEM_READ), 32'h1);
    tick(1'b0, 32'h180, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    check("fl_read_done", 32'(IMEM_READ), 32'h0);
    check("fl_discard", 32'(IF_VALID), 32'h0);
    tick(1'b1, 32'h200, 1'b0, 32'h00B00193, 1'b1, 1'b0);
    tick(1'b0, 32'h200, 1'b0, 32'h00B00193, 1'b1, 1'b0);
    check("fl_refetch_instr", IF_INSTR, 32'h00B00193);
    check("fl_refetch_pc", IF_PC, 32'h200);

    // Misaligned PC, output freed by a transfer on the same edge
    tick(1'b1, 32'h102, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
    check("ma_read", 32'(IMEM_READ), 32'h0);
    check("ma_valid", 32'(IF_VALID), 32'h1);
    check("ma_flag", 32'(IF_MISALIGN), 32'h1);
    check("ma_instr", IF_INSTR, 32'h00000013);
    check("ma_pc", IF_PC, 32'h102);
    check("ma_accept", 32'(PC_ACCEPT), 32'h1);
    tick(1'b0, 32'h102, 1'b0, 32'h0, 1'b1, 1'b0);
    check("ma_cleared", 32'(IF_MISALIGN), 32'h0);

    // Asynchronous reset in the middle of a fetch
    tick(1'b1, 32'h2FC, 1'b0, 32'h33333333, 1'b0, 1'b0);
    tick(1'b0, 32'h2FC, 1'b0, 32'h33333333, 1'b0, 1'b0);
    tick(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    PC_VALID = 1'b0; IMEM_BUSY = 1'b1;
    #2 RESET = 1'b1;
    #1;
    check("ar_read", 32'(IMEM_READ), 32'h0);
    check("ar_valid", 32'(IF_VALID), 32'h0);
    check("ar_instr", IF_INSTR, NOP);
    check("ar_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    tick(1'b1, 32'h0, 1'b0, 32'h00100093, 1'b1, 1'b0);
    check("ar_fetch_accept", 32'(PC_ACCEPT), 32'h1);
    tick(1'b0, 32'h0, 1'b0, 32'h00100093, 1'b1, 1'b0);
    check("ar_fetch_instr", IF_INSTR, 32'h00100093);
    check("ar_fetch_pc", IF_PC, 32'h0);
    check("ar_fetch_valid", 32'(IF_VALID), 32'h1);

    // Randomized traffic against a PC register
    pc_cur = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      bit fl;
      if (m_acc) pc_cur = ($urandom_range(0, 9) == 0) ? pc_cur + 32'd2 : pc_cur + 32'd4;
      fl = ($urandom_range(0, 99) < 5);
      tick($urandom_range(0, 99) < 80, pc_cur, $urandom_range(0, 99) < 40,
           $urandom, $urandom_range(0, 99) < 70, fl);
      if (fl) begin
        pc_cur = $urandom & 32'h0000FFFF;
        if ($urandom_range(0, 99) < 80) pc_cur = pc_cur & 32'hFFFFFFFC;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
